tactile_scan_ctrl: RTL and testbench
====================================

TACTILE_SCAN_CTRL -- requirements
Module: tactile_scan_ctrl

Interface
REQ-001 SHALL have parameter SW_WIRE_CNT, default 16, switching-wire count.
REQ-002 SHALL have parameter RD_WIRE_CNT, default 16, read-wire count.
REQ-003 SHALL have parameter ADC_BITS, default 12, sample width.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 8, mux settle time in clocks (legal range 1 or more).
REQ-005 SHALL have parameter AVG_LOG2, default 2, log2 of samples averaged per taxel (legal range 0 or more).
REQ-006 SHALL have these ports:
- clk_in, input, 1 bit, the only clock.
- rst_n_in, input, 1 bit, reset; synchronous, active-low.
- enable_in, input, 1 bit, scanning permitted.
- single_shot_in, input, 1 bit: 1 = one frame then stop; 0 = continuous.
- start_in, input, 1 bit, begins a frame from IDLE.
- adc_start_out, output, 1 bit, one-cycle conversion request.
- adc_done_in, input, 1 bit, conversion complete; adc_data_in is valid in the same cycle.
- adc_data_in, input, ADC_BITS bits, conversion result.
- sw_sel_out, output, $clog2(SW_WIRE_CNT) bits, switching mux select.
- rd_sel_out, output, $clog2(RD_WIRE_CNT) bits, read mux select.
- taxel_data_out, output, ADC_BITS bits, averaged taxel value.
- taxel_addr_out, output, $clog2(SW_WIRE_CNT*RD_WIRE_CNT) bits, address = sw*RD_WIRE_CNT + rd.
- taxel_valid_out, output, 1 bit; taxel_ready_in, input, 1 bit; together the output handshake.
- frame_done_out, output, 1 bit, one-cycle pulse at end of frame.
- busy_out, output, 1 bit, 1 whenever the state is not IDLE.
- frame_count_out, output, 16 bits, count of completed frames.

Function
REQ-007 SHALL implement the states IDLE, SETTLE, CONVERT, WAIT and OUTPUT.
REQ-008 In IDLE, SHALL go to SETTLE when either condition holds:
- enable_in && start_in;
- enable_in && !single_shot_in.
On entry, sw/rd selects are 0.
REQ-009 SETTLE SHALL count SETTLE_CYCLES clocks, then go to CONVERT.
REQ-010 CONVERT SHALL assert adc_start_out for exactly 1 cycle, then go to WAIT.
REQ-011 In WAIT, on adc_done_in, SHALL add adc_data_in (zero-extended) to an accumulator of ADC_BITS+AVG_LOG2 bits.
REQ-012 After 2^AVG_LOG2 samples, SHALL go to OUTPUT; otherwise SHALL return to CONVERT without re-settling.
REQ-013 On entering OUTPUT, SHALL present:
- taxel_data_out = accumulator >> AVG_LOG2 (truncating);
- taxel_valid_out = 1, in the cycle after the final adc_done_in.
REQ-014 While taxel_valid_out && !taxel_ready_in, data and address SHALL stay stable and no adc_start_out SHALL issue.
REQ-015 On taxel_valid_out && taxel_ready_in, SHALL:
- deassert valid next cycle;
- clear the accumulator;
- advance rd_sel (fastest), and on rd wrap advance sw_sel;
- enter SETTLE.
REQ-016 On acceptance of the last taxel (sw=SW_WIRE_CNT-1, rd=RD_WIRE_CNT-1), in the same cycle SHALL:
- pulse frame_done_out;
- increment frame_count_out, wrapping 65535->0;
- reset both selects to 0.
REQ-017 After the last taxel, SHALL go to SETTLE if enable_in && !single_shot_in, else to IDLE.
REQ-018 enable_in deasserted mid-frame SHALL take effect only at the frame boundary; a frame in progress SHALL always complete.
REQ-019 adc_done_in outside WAIT SHALL be ignored.
REQ-020 In the CONVERT->WAIT cycle, adc_done_in SHALL be ignored; samples are counted only in WAIT.
REQ-021 start_in outside IDLE SHALL be ignored.
REQ-022 Selects SHALL change only on the acceptance cycle or at the frame wrap, never during SETTLE, CONVERT or WAIT.

Reset
REQ-023 When rst_n_in=0 at a clock edge, SHALL:
- go to IDLE;
- zero all outputs, the accumulator, sample counter, settle counter and frame_count_out.
REQ-024 Reset mid-operation SHALL abandon any pending conversion; a later adc_done_in SHALL be ignored per REQ-019.

Structure
REQ-025 The state enum and the default ADC_BITS constant SHALL reside in the shared package tactile_pkg.
REQ-026 Accumulation and sample counting SHALL be a sub-module taxel_accum, with these ports:
- clear, add, data;
- sum, last.

Verification
REQ-027 Each scenario uses SW=4, RD=4, SETTLE_CYCLES=3, AVG_LOG2=2 and the stimulus and required response below.
- Reset: hold rst_n_in=0 for 2 cycles. All outputs must be 0, busy_out=0.
- Averaging: feed samples 100, 101, 102, 103. taxel_data_out=101 at addr 0. Also feed 4095 ×4: output must be 4095 with no overflow.
- Backpressure: hold taxel_ready_in=0 for 10 cycles. Data and addr must stay stable, adc_start_out=0 throughout. After ready, the next taxel must be addr 1 with rd_sel=1.
- Frame wrap: continuous mode, ready=1. frame_done_out must pulse once, on acceptance of addr 15. frame_count_out=1; selects must return to 0,0 and the scan must continue.
- Single-shot: start_in pulse, single_shot_in=1. Exactly 16 taxels must be produced, then IDLE with busy_out=0. A later start_in must run a second frame, giving frame_count_out=2.
- Reset mid-WAIT: drop rst_n_in, then assert adc_done_in. State must be IDLE, taxel_valid_out=0 and the accumulator 0.

Source files
------------

// File: rtl/tactile_pkg.sv
// Shared types and constants for the tactile array scan controller.
package tactile_pkg;

    localparam int ADC_BITS_DEF = 12;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CONVERT,
        WAIT,
        OUTPUT
    } scan_state_e;

endpackage

// File: rtl/tactile_scan_ctrl_accum.sv
// Per-taxel sample accumulator and sample counter.
module taxel_accum
    import tactile_pkg::*;
#(
    parameter int DW       = ADC_BITS_DEF,
    parameter int AVG_LOG2 = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   add,
    input  logic [DW-1:0]          data,
    output logic [DW+AVG_LOG2-1:0] sum,
    output logic                   last
);

    localparam int SUMW = DW + AVG_LOG2;
    localparam int CW   = AVG_LOG2 + 1;
    localparam int NS   = 1 << AVG_LOG2;

    logic [SUMW-1:0] sum_q, sum_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // last flags that the sample being added now completes the average
    assign last = (cnt_q == CW'(NS - 1));
    assign sum  = sum_q;

    always_comb begin
        sum_d = sum_q;
        cnt_d = cnt_q;
        if (clear) begin
            sum_d = '0;
            cnt_d = '0;
        end else if (add) begin
            sum_d = sum_q + SUMW'(data);
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tactile_scan_ctrl.sv
// Scans a switching x read wire matrix, averages ADC samples per taxel
// and streams the results over a valid/ready handshake.
module tactile_scan_ctrl
    import tactile_pkg::*;
#(
    parameter int SW_WIRE_CNT   = 16,
    parameter int RD_WIRE_CNT   = 16,
    parameter int ADC_BITS      = ADC_BITS_DEF,
    parameter int SETTLE_CYCLES = 8,
    parameter int AVG_LOG2      = 2
) (
    input  logic                                     clk_in,
    input  logic                                     rst_n_in,
    input  logic                                     enable_in,
    input  logic                                     single_shot_in,
    input  logic                                     start_in,
    output logic                                     adc_start_out,
    input  logic                                     adc_done_in,
    input  logic [ADC_BITS-1:0]                      adc_data_in,
    output logic [$clog2(SW_WIRE_CNT)-1:0]           sw_sel_out,
    output logic [$clog2(RD_WIRE_CNT)-1:0]           rd_sel_out,
    output logic [ADC_BITS-1:0]                      taxel_data_out,
    output logic [$clog2(SW_WIRE_CNT*RD_WIRE_CNT)-1:0] taxel_addr_out,
    output logic                                     taxel_valid_out,
    input  logic                                     taxel_ready_in,
    output logic                                     frame_done_out,
    output logic                                     busy_out,
    output logic [15:0]                              frame_count_out
);

    localparam int SWW  = $clog2(SW_WIRE_CNT);
    localparam int RDW  = $clog2(RD_WIRE_CNT);
    localparam int AW   = $clog2(SW_WIRE_CNT * RD_WIRE_CNT);
    localparam int ACW  = ADC_BITS + AVG_LOG2;
    localparam int SCW  = $clog2(SETTLE_CYCLES + 1);

    scan_state_e    state_q, state_d;
    logic [SWW-1:0] sw_q, sw_d;
    logic [RDW-1:0] rd_q, rd_d;
    logic [SCW-1:0] settle_q, settle_d;
    logic [15:0]    fcnt_q, fcnt_d;

    logic           acc_clear, acc_add, acc_last;
    logic [ACW-1:0] acc_sum;
    logic           fdone;
    logic           rd_wrap, sw_wrap;
    logic           go;

    taxel_accum #(
        .DW       (ADC_BITS),
        .AVG_LOG2 (AVG_LOG2)
    ) u_acc (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .clear (acc_clear),
        .add   (acc_add),
        .data  (adc_data_in),
        .sum   (acc_sum),
        .last  (acc_last)
    );

    assign rd_wrap = (rd_q == RDW'(RD_WIRE_CNT - 1));
    assign sw_wrap = (sw_q == SWW'(SW_WIRE_CNT - 1));
    assign go      = enable_in && (start_in || !single_shot_in);

    always_comb begin
        state_d   = state_q;
        sw_d      = sw_q;
        rd_d      = rd_q;
        settle_d  = settle_q;
        fcnt_d    = fcnt_q;
        acc_clear = 1'b0;
        acc_add   = 1'b0;
        fdone     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    state_d  = SETTLE;
                    settle_d = '0;
                    sw_d     = '0;
                    rd_d     = '0;
                end
            end
            SETTLE: begin
                if (settle_q == SCW'(SETTLE_CYCLES - 1)) begin
                    state_d  = CONVERT;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            CONVERT: state_d = WAIT;
            WAIT: begin
                if (adc_done_in) begin
                    acc_add = 1'b1;
                    state_d = acc_last ? OUTPUT : CONVERT;
                end
            end
            OUTPUT: begin
                if (taxel_ready_in) begin
                    acc_clear = 1'b1;
                    settle_d  = '0;
                    state_d   = SETTLE;
                    if (!rd_wrap) begin
                        rd_d = rd_q + 1'b1;
                    end else begin
                        rd_d = '0;
                        if (!sw_wrap) begin
                            sw_d = sw_q + 1'b1;
                        end else begin
                            // frame boundary: the only point enable_in is honoured
                            sw_d   = '0;
                            fdone  = 1'b1;
                            fcnt_d = fcnt_q + 1'b1;
                            if (!(enable_in && !single_shot_in))
                                state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            sw_q     <= '0;
            rd_q     <= '0;
            settle_q <= '0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            sw_q     <= sw_d;
            rd_q     <= rd_d;
            settle_q <= settle_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign adc_start_out   = (state_q == CONVERT);
    assign busy_out        = (state_q != IDLE);
    assign taxel_valid_out = (state_q == OUTPUT);
    assign taxel_data_out  = taxel_valid_out ? acc_sum[ACW-1:AVG_LOG2] : '0;
    assign taxel_addr_out  = AW'(sw_q) * AW'(RD_WIRE_CNT) + AW'(rd_q);
    assign sw_sel_out      = sw_q;
    assign rd_sel_out      = rd_q;
    assign frame_done_out  = fdone;
    assign frame_count_out = fcnt_q;

endmodule

// File: tb/tb_tactile_scan_ctrl.sv
// Directed bench for tactile_scan_ctrl on a 4x4 array.
module tb_tactile_scan_ctrl;
    import tactile_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        single_shot = 1'b1;
    logic        start = 1'b0;
    logic        adc_start;
    logic        adc_done;
    logic [11:0] adc_data;
    logic [1:0]  sw_sel, rd_sel;
    logic [11:0] t_data;
    logic [3:0]  t_addr;
    logic        t_valid;
    logic        t_ready = 1'b0;
    logic        f_done;
    logic        busy;
    logic [15:0] f_cnt;

    int checks = 0;
    int failures = 0;
    int acc_cnt = 0;
    int fd_cnt = 0;
    int adc_lat = 2;
    logic [11:0] tab [8];

    always #5 clk = ~clk;

    tactile_scan_ctrl #(
        .SW_WIRE_CNT   (4),
        .RD_WIRE_CNT   (4),
        .ADC_BITS      (12),
        .SETTLE_CYCLES (3),
        .AVG_LOG2      (2)
    ) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .enable_in       (enable),
        .single_shot_in  (single_shot),
        .start_in        (start),
        .adc_start_out   (adc_start),
        .adc_done_in     (adc_done),
        .adc_data_in     (adc_data),
        .sw_sel_out      (sw_sel),
        .rd_sel_out      (rd_sel),
        .taxel_data_out  (t_data),
        .taxel_addr_out  (t_addr),
        .taxel_valid_out (t_valid),
        .taxel_ready_in  (t_ready),
        .frame_done_out  (f_done),
        .busy_out        (busy),
        .frame_count_out (f_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // ADC model: answers each conversion request after adc_lat cycles
    initial begin
        int si;
        si = 0;
        adc_done = 1'b0;
        adc_data = '0;
        @(posedge clk); #1;
        forever begin
            if (adc_start) begin
                repeat (adc_lat) @(posedge clk);
                #1;
                adc_done = 1'b1;
                if (si < 8) adc_data = tab[si];
                else adc_data = 12'd200;
                si++;
                @(posedge clk); #1;
                adc_done = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (rst_n && t_valid && t_ready) acc_cnt++;
            if (f_done) fd_cnt++;
        end
    end

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!t_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!t_valid) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk({tag, "_timeout"}, 1, 0);
    endtask

    initial begin
        logic [11:0] d0;
        logic [3:0]  a0;
        logic        bad, any_start;
        int          n, fd0;

        tab[0] = 12'd100; tab[1] = 12'd101;
        tab[2] = 12'd102; tab[3] = 12'd103;
        for (int i = 4; i < 8; i++) tab[i] = 12'd4095;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_adc_start", adc_start, 0);
        chk("rst_sel", {sw_sel, rd_sel}, 0);
        chk("rst_data", t_data, 0);
        chk("rst_addr", t_addr, 0);
        chk("rst_valid", t_valid, 0);
        chk("rst_fdone", f_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fcnt", f_cnt, 0);

        rst_n = 1'b1;
        enable = 1'b1;
        single_shot = 1'b1;
        @(negedge clk);
        chk("idle_hold", busy, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);

        wait_valid("avg0");
        chk("avg0_data", t_data, 101);
        chk("avg0_addr", t_addr, 0);

        d0 = t_data;
        a0 = t_addr;
        bad = 1'b0;
        any_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (t_data !== d0 || t_addr !== a0 || !t_valid) bad = 1'b1;
            if (adc_start) any_start = 1'b1;
        end
        chk("bp_stable", bad, 0);
        chk("bp_no_adc_start", any_start, 0);

        t_ready = 1'b1;
        @(negedge clk);
        t_ready = 1'b0;
        chk("bp_valid_drop", t_valid, 0);
        chk("bp_rd_sel", rd_sel, 1);

        wait_valid("avg1");
        chk("avg1_data", t_data, 4095);
        chk("avg1_addr", t_addr, 1);
        chk("avg1_rd_sel", rd_sel, 1);

        t_ready = 1'b1;
        wait_idle("ss1");
        chk("ss1_taxels", acc_cnt, 16);
        chk("ss1_fdone", fd_cnt, 1);
        chk("ss1_fcnt", f_cnt, 1);
        chk("ss1_sel", {sw_sel, rd_sel}, 0);

        repeat (5) @(negedge clk);
        chk("ss_stays_idle", busy, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("ss2");
        chk("ss2_taxels", acc_cnt, 32);
        chk("ss2_fcnt", f_cnt, 2);

        single_shot = 1'b0;
        n = 0;
        @(negedge clk);
        while (!f_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("wrap_seen", f_done, 1);
        chk("wrap_addr", t_addr, 15);
        chk("wrap_data", t_data, 200);
        @(posedge clk); #1;
        chk("wrap_sel", {sw_sel, rd_sel}, 0);
        chk("wrap_busy", busy, 1);
        chk("wrap_fcnt", f_cnt, 3);
        fd0 = fd_cnt;
        repeat (100) @(negedge clk);
        chk("wrap_single_pulse", fd_cnt - fd0, 0);

        enable = 1'b0;
        wait_idle("dis");
        chk("dis_taxels", acc_cnt, 64);
        chk("dis_fcnt", f_cnt, 4);
        chk("dis_fdone", fd_cnt, 4);

        adc_lat = 8;
        enable = 1'b1;
        single_shot = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (dut.state_q != WAIT && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_wait_reached", 32'(dut.state_q), 32'(WAIT));
        rst_n = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("mrst_state", 32'(dut.state_q), 32'(IDLE));
        chk("mrst_busy", busy, 0);
        chk("mrst_valid", t_valid, 0);
        chk("mrst_accum", 32'(dut.acc_sum), 0);
        chk("mrst_fcnt", f_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
